display_scan_buffer: RTL
========================

Name: display_scan_buffer

Overview:
- Typewriter-style digit buffer and multiplexed-display scanner, sitting directly upstream of the 7-segment decoder.
- Accepts key codes from the keypad path and shifts them into a right-justified NUM_DIGITS buffer; supports backspace and clear.
- Time-multiplexes the buffer: drives the decoder's 4-bit digit input plus a one-hot anode select.
- The decoder cannot blank, so empty positions are suppressed here by disabling the anode.

Parameters:
- NUM_DIGITS, 4, number of display positions; legal range >= 2.
- SCAN_DIV, 50000, clk cycles each position stays lit; legal range >= 1 (1 = advance every cycle).
- ANODE_ACTIVE_LOW, 1, 1: active anode driven 0; 0: active anode driven 1.

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, asynchronous active-low reset.
- key_valid, input, 1, single-cycle strobe: push key_code.
- key_code, input, 4, code 0x0-0xF (0-9, A-d, 0xE='*', 0xF='#').
- bksp, input, 1, single-cycle strobe: delete newest digit.
- clear, input, 1, single-cycle strobe: empty buffer.
- current_digit, output, 4, code of the position being scanned; feeds the decoder.
- digit_blank, output, 1, 1 when the scanned position is empty.
- anode, output, NUM_DIGITS, one-hot position enable (polarity per ANODE_ACTIVE_LOW).
- scan_idx, output, $clog2(NUM_DIGITS), index of the scanned position; 0 = rightmost.
- fill_count, output, $clog2(NUM_DIGITS+1), number of valid digits.
- buf_full, output, 1, fill_count == NUM_DIGITS.

Behaviour:
- Clock and reset: single clock domain. rst_n is asynchronous and active-low.
- Reset values: buffer all 0, fill_count=0, scan_idx=0, prescaler=0, current_digit=0, digit_blank=1, anode all inactive, buf_full=0.
- Reset mid-operation: asserting rst_n low at any time immediately forces all reset values; no partial state survives.
- Storage: digit[0] is rightmost/newest; digit[NUM_DIGITS-1] is leftmost/oldest. Positions at index >= fill_count are empty.
- Command priority, evaluated once per cycle; lower-priority strobes in the same cycle are dropped:
  - clear > bksp > key_valid.
- clear: all digits <= 0; fill_count <= 0.
- key_valid (push):
  - digit[i] <= digit[i-1] for i >= 1; digit[0] <= key_code.
  - fill_count <= min(fill_count+1, NUM_DIGITS).
  - When full, the oldest digit is shifted out and lost; fill_count stays NUM_DIGITS.
- bksp:
  - If fill_count == 0: no-op.
  - Otherwise digit[i] <= digit[i+1]; digit[NUM_DIGITS-1] <= 0; fill_count decrements.
- Strobe handling: inputs are sampled on every cycle they are high. No edge detection; a strobe held high for k cycles acts k times.
- Prescaler: counts 0..SCAN_DIV-1, then wraps to 0.
  - In the wrap cycle, scan_idx advances: NUM_DIGITS-1 wraps to 0.
  - Buffer commands never reset the prescaler or scan_idx.
- Output decode: all outputs below are combinational from registered state, so they reflect a buffer update in the cycle after the command edge.
  - digit_blank = (scan_idx >= fill_count).
  - current_digit = digit_blank ? 4'h0 : digit[scan_idx].
  - anode: bit scan_idx active only when digit_blank == 0; all other bits inactive.
  - buf_full = (fill_count == NUM_DIGITS).
- Width rules: fill_count saturates and never wraps. scan_idx comparison is unsigned.
- Non-power-of-two NUM_DIGITS: scan_idx never takes values >= NUM_DIGITS.

Test Plan:
- Setup: NUM_DIGITS=4, SCAN_DIV=4, ANODE_ACTIVE_LOW=1.
- Reset, then idle 32 cycles -> anode=4'b1111 throughout, digit_blank=1, current_digit=0, scan_idx sequence 0,1,2,3,0 with 4 cycles per step.
- Push 1,2,3 -> fill_count=3, digit[2:0]=1,2,3.
  - At scan_idx=0: current_digit=3, anode=4'b1110.
  - At scan_idx=3: digit_blank=1, anode=4'b1111.
- Push 1,2,3,4,5 -> buf_full=1, fill_count=4, digits (left..right) = 2,3,4,5. At scan_idx=3: current_digit=2, anode=4'b0111.
- From contents 2,3,4,5: bksp x2 -> fill_count=2, digit[1:0]=2,3. Then bksp x3 -> fill_count=0, no underflow, all digits 0.
- Simultaneous events:
  - clear+bksp+key_valid(code 7) in one cycle -> buffer empty, fill_count=0.
  - bksp+key_valid with fill_count=2 -> only backspace occurs, fill_count=1.
- Async reset mid-operation: rst_n low for half a clk period mid-scan with fill_count=3 -> outputs reach reset values before the next clk edge. After release, the scan restarts at scan_idx=0 with the prescaler at 0.

Source files
------------

// File: rtl/display_scan_buffer.sv
// Typewriter-style digit buffer with a multiplexed 7-segment scanner.
// digits[0] holds the newest key and is shown rightmost; empty positions are blanked by disabling the anode.
module display_scan_buffer #(
  parameter int NUM_DIGITS       = 4,
  parameter int SCAN_DIV         = 50000,
  parameter int ANODE_ACTIVE_LOW = 1,
  localparam int IDX_W = $clog2(NUM_DIGITS),
  localparam int CNT_W = $clog2(NUM_DIGITS + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  key_valid,
  input  logic [3:0]            key_code,
  input  logic                  bksp,
  input  logic                  clear,
  output logic [3:0]            current_digit,
  output logic                  digit_blank,
  output logic [NUM_DIGITS-1:0] anode,
  output logic [IDX_W-1:0]      scan_idx,
  output logic [CNT_W-1:0]      fill_count,
  output logic                  buf_full
);

  localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [3:0]            digits [NUM_DIGITS];
  logic [PRE_W-1:0]      presc;
  logic                  scan_wrap;
  logic [NUM_DIGITS-1:0] sel;

  // Command interface: key_valid, bksp and clear are level-sampled strobes with
  // no ready/backpressure; every cycle a strobe is high it acts once, and only
  // the highest-priority one (clear > bksp > key_valid) acts in that cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) digits[i] <= 4'h0;
      fill_count <= '0;
    end else if (clear) begin
      for (int i = 0; i < NUM_DIGITS; i++) digits[i] <= 4'h0;
      fill_count <= '0;
    end else if (bksp) begin
      if (fill_count != '0) begin
        for (int i = 0; i < NUM_DIGITS - 1; i++) digits[i] <= digits[i+1];
        digits[NUM_DIGITS-1] <= 4'h0;
        fill_count <= fill_count - 1'b1;
      end
    end else if (key_valid) begin
      for (int i = NUM_DIGITS - 1; i >= 1; i--) digits[i] <= digits[i-1];
      digits[0] <= key_code;
      // When full the oldest digit falls off the left end and the count saturates.
      if (fill_count != CNT_W'(NUM_DIGITS)) fill_count <= fill_count + 1'b1;
    end
  end

  assign scan_wrap = (presc == PRE_W'(SCAN_DIV - 1));

  // Scan timing is free-running; buffer commands never disturb it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc    <= '0;
      scan_idx <= '0;
    end else if (scan_wrap) begin
      presc <= '0;
      if (scan_idx == IDX_W'(NUM_DIGITS - 1)) scan_idx <= '0;
      else                                    scan_idx <= scan_idx + 1'b1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  assign digit_blank   = (CNT_W'(scan_idx) >= fill_count);
  assign current_digit = digit_blank ? 4'h0 : digits[scan_idx];
  assign buf_full      = (fill_count == CNT_W'(NUM_DIGITS));

  always_comb begin
    sel = '0;
    if (!digit_blank) sel[scan_idx] = 1'b1;
  end

  assign anode = (ANODE_ACTIVE_LOW != 0) ? ~sel : sel;

endmodule
